// File: rtl/generic_fifo_pkg.sv
// -----------------------------------------------------------------------------
// generic_fifo_pkg
//   Shared helpers for generic_fifo_lvl and its storage sub-module:
//   - lvl_width    : width of an occupancy counter able to hold 0..depth
//   - ptr_width    : width of a read/write pointer for 0..depth-1
//   - ptr_wrap_inc : pointer increment with explicit wrap depth-1 -> 0, so
//                    non-power-of-two depths never rely on modulo-2^n overflow
//   - fifo_op_e    : per-cycle handshake outcome used to update the level
// -----------------------------------------------------------------------------
package generic_fifo_pkg;

   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_PUSH = 2'b01,
      OP_POP  = 2'b10,
      OP_BOTH = 2'b11
   } fifo_op_e;

   function automatic int unsigned lvl_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int unsigned ptr_wrap_inc(input int unsigned ptr,
                                                input int unsigned depth);
      return (ptr >= depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/generic_fifo_lvl_mem.sv
// -----------------------------------------------------------------------------
// generic_fifo_lvl_mem
//   DATA_DEPTH x DATA_WIDTH register array, one synchronous write port and one
//   asynchronous read port. Contents are never reset.
//
//   Optional macro GENERIC_FIFO_LVL_CG_EN:
//     defined   - storage runs on a clock gated by cluster_clock_gating,
//                 enabled only when writing; test_mode_i forces it on.
//     undefined - storage runs on clk with a plain write enable;
//                 test_mode_i is unused.
//
// Ports
//   clk          in   clock
//   test_mode_i  in   clock-gate bypass (gated build only)
//   we_i         in   write enable
//   waddr_i      in   write address
//   wdata_i      in   write data
//   raddr_i      in   read address
//   rdata_o      out  read data (combinational)
// -----------------------------------------------------------------------------
module generic_fifo_lvl_mem
   import generic_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DATA_DEPTH = 8,
   parameter int unsigned PTR_W      = ptr_width(DATA_DEPTH)
) (
   input  logic                  clk,
   input  logic                  test_mode_i,
   input  logic                  we_i,
   input  logic [PTR_W-1:0]      waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [PTR_W-1:0]      raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

`ifdef GENERIC_FIFO_LVL_CG_EN
   logic clk_gated;

   cluster_clock_gating u_clk_gate (
      .clk_i     (clk),
      .en_i      (we_i),
      .test_en_i (test_mode_i),
      .clk_o     (clk_gated)
   );

   // we_i is still qualified: in test mode the gated clock runs every cycle.
   always_ff @(posedge clk_gated) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
   end
`else
   logic unused_test_mode;
   assign unused_test_mode = test_mode_i;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
   end
`endif

   assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/generic_fifo_lvl.sv
// -----------------------------------------------------------------------------
// generic_fifo_lvl
//   Single-clock FIFO with arbitrary depth, occupancy level, programmable
//   almost-full / almost-empty flags and optional zero-latency fall-through.
//   Push = valid_i & grant_o, pop = valid_o & grant_i. grant_o depends only on
//   the registered level, so there is no combinational pop->push path.
//
//   Optional macro GENERIC_FIFO_LVL_CG_EN (see generic_fifo_lvl_mem): gates
//   the storage clock on writes; control registers always run on clk.
//
// Parameters
//   DATA_WIDTH     payload width
//   DATA_DEPTH     number of entries (>= 2, any integer)
//   FALL_THROUGH   1 = empty FIFO forwards data_i/valid_i combinationally
//   AFULL_THRESH   almost_full_o  when level >= AFULL_THRESH
//   AEMPTY_THRESH  almost_empty_o when level <= AEMPTY_THRESH
//
// Ports
//   clk             in   clock, rising edge
//   rst             in   synchronous active-high reset (priority over clear_i)
//   clear_i         in   synchronous flush (priority over push/pop)
//   data_i/valid_i  in   push side
//   grant_o         out  FIFO can accept data
//   data_o/valid_o  out  head of queue
//   grant_i         in   consumer accepts head
//   level_o         out  occupancy 0..DATA_DEPTH
//   almost_full_o   out  level_o >= AFULL_THRESH
//   almost_empty_o  out  level_o <= AEMPTY_THRESH
//   test_mode_i     in   clock-gate bypass (gated build only)
// -----------------------------------------------------------------------------
module generic_fifo_lvl
   import generic_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned DATA_DEPTH    = 8,
   parameter int unsigned FALL_THROUGH  = 0,
   parameter int unsigned AFULL_THRESH  = DATA_DEPTH - 1,
   parameter int unsigned AEMPTY_THRESH = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              clear_i,
   input  logic [DATA_WIDTH-1:0]             data_i,
   input  logic                              valid_i,
   output logic                              grant_o,
   output logic [DATA_WIDTH-1:0]             data_o,
   output logic                              valid_o,
   input  logic                              grant_i,
   output logic [lvl_width(DATA_DEPTH)-1:0]  level_o,
   output logic                              almost_full_o,
   output logic                              almost_empty_o,
   input  logic                              test_mode_i
);

   localparam int unsigned PTR_W = ptr_width(DATA_DEPTH);
   localparam int unsigned LVL_W = lvl_width(DATA_DEPTH);
   localparam bit          FT    = (FALL_THROUGH != 0);

   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DATA_DEPTH);
   localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(AFULL_THRESH);
   localparam logic [LVL_W-1:0] LVL_AE   = LVL_W'(AEMPTY_THRESH);

   // Parameter legality, caught at elaboration
   if (DATA_WIDTH < 1) begin : g_bad_width
      $error("generic_fifo_lvl: DATA_WIDTH must be >= 1");
   end
   if (DATA_DEPTH < 2) begin : g_bad_depth
      $error("generic_fifo_lvl: DATA_DEPTH must be >= 2");
   end
   if (AFULL_THRESH > DATA_DEPTH) begin : g_bad_afull
      $error("generic_fifo_lvl: AFULL_THRESH must be <= DATA_DEPTH");
   end
   if (AEMPTY_THRESH >= DATA_DEPTH) begin : g_bad_aempty
      $error("generic_fifo_lvl: AEMPTY_THRESH must be < DATA_DEPTH");
   end

   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      wr_ptr;
   logic [LVL_W-1:0]      level;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  empty;
   logic                  full;
   logic                  bypass;
   logic                  push;
   logic                  pop;
   logic                  mem_we;
   fifo_op_e              op;

   assign empty = (level == '0);
   assign full  = (level == LVL_FULL);

   assign grant_o = ~full;

   // Head presentation. In fall-through mode an empty FIFO shows the
   // producer's word directly; a same-cycle accept then bypasses storage.
   always_comb begin
      valid_o = ~empty;
      data_o  = mem_rdata;
      bypass  = 1'b0;
      if (FT && empty) begin
         valid_o = valid_i;
         data_o  = data_i;
         bypass  = valid_i & grant_i;
      end
   end

   // A bypassed word is both pushed and popped at the ports, but must not
   // touch memory, pointers or level, so it is removed from both sides here.
   assign push   = valid_i & grant_o & ~bypass;
   assign pop    = valid_o & grant_i & ~bypass;
   assign op     = fifo_op_e'({pop, push});
   assign mem_we = push & ~clear_i & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
      end else if (clear_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= PTR_W'(ptr_wrap_inc(32'(wr_ptr), DATA_DEPTH));
         end
         if (pop) begin
            rd_ptr <= PTR_W'(ptr_wrap_inc(32'(rd_ptr), DATA_DEPTH));
         end
         case (op)
            OP_PUSH: level <= level + LVL_W'(1);
            OP_POP:  level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   assign level_o        = level;
   assign almost_full_o  = (level >= LVL_AF);
   assign almost_empty_o = (level <= LVL_AE);

   generic_fifo_lvl_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DATA_DEPTH (DATA_DEPTH),
      .PTR_W      (PTR_W)
   ) u_mem (
      .clk         (clk),
      .test_mode_i (test_mode_i),
      .we_i        (mem_we),
      .waddr_i     (wr_ptr),
      .wdata_i     (data_i),
      .raddr_i     (rd_ptr),
      .rdata_o     (mem_rdata)
   );

endmodule

// File: tb/tb_generic_fifo_lvl.sv
// -----------------------------------------------------------------------------
// tb_generic_fifo_lvl
//   Two instances with DATA_DEPTH=5, DATA_WIDTH=8: u_a (registered head) and
//   u_b (fall-through). Words accepted by u_a are queued in expq; a monitor
//   pops and compares whenever u_a hands out its head. Level and flag values
//   are hand-computed per step.
// -----------------------------------------------------------------------------
module tb_generic_fifo_lvl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic       a_clear, a_valid_i, a_grant_i, a_grant_o, a_valid_o, a_af, a_ae;
   logic [7:0] a_data_i, a_data_o;
   logic [2:0] a_level;

   logic       b_clear, b_valid_i, b_grant_i, b_grant_o, b_valid_o, b_af, b_ae;
   logic [7:0] b_data_i, b_data_o;
   logic [2:0] b_level;

   int unsigned vecs = 0;
   int unsigned errs = 0;
   logic [7:0]  expq [$];

   generic_fifo_lvl #(
      .DATA_WIDTH   (8),
      .DATA_DEPTH   (5),
      .FALL_THROUGH (0)
   ) u_a (
      .clk            (clk),
      .rst            (rst),
      .clear_i        (a_clear),
      .data_i         (a_data_i),
      .valid_i        (a_valid_i),
      .grant_o        (a_grant_o),
      .data_o         (a_data_o),
      .valid_o        (a_valid_o),
      .grant_i        (a_grant_i),
      .level_o        (a_level),
      .almost_full_o  (a_af),
      .almost_empty_o (a_ae),
      .test_mode_i    (1'b0)
   );

   generic_fifo_lvl #(
      .DATA_WIDTH   (8),
      .DATA_DEPTH   (5),
      .FALL_THROUGH (1)
   ) u_b (
      .clk            (clk),
      .rst            (rst),
      .clear_i        (b_clear),
      .data_i         (b_data_i),
      .valid_i        (b_valid_i),
      .grant_o        (b_grant_o),
      .data_o         (b_data_o),
      .valid_o        (b_valid_o),
      .grant_i        (b_grant_i),
      .level_o        (b_level),
      .almost_full_o  (b_af),
      .almost_empty_o (b_ae),
      .test_mode_i    (1'b0)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor for u_a: every accepted head must match the oldest
   // outstanding pushed word.
   always @(negedge clk) begin
      if (!rst && a_valid_o && a_grant_i) begin
         if (expq.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL a_pop: got 0x%0h, expected no word available", a_data_o);
         end else begin
            chk("a_pop_data", 32'(a_data_o), 32'(expq.pop_front()));
         end
      end
   end

   // Inputs change 1 time unit after the rising edge; outputs are observed on
   // the falling edge.
   task automatic apply_a(input logic v, input logic [7:0] d, input logic g, input logic c);
      a_valid_i = v;
      a_data_i  = d;
      a_grant_i = g;
      a_clear   = c;
      @(negedge clk);
   endtask

   task automatic apply_b(input logic v, input logic [7:0] d, input logic g);
      b_valid_i = v;
      b_data_i  = d;
      b_grant_i = g;
      b_clear   = 1'b0;
      @(negedge clk);
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      a_clear = 1'b0; a_valid_i = 1'b0; a_grant_i = 1'b0; a_data_i = '0;
      b_clear = 1'b0; b_valid_i = 1'b0; b_grant_i = 1'b0; b_data_i = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      apply_a(1'b0, 8'h00, 1'b0, 1'b0);
      chk("rst_grant",  32'(a_grant_o), 32'd1);
      chk("rst_valid",  32'(a_valid_o), 32'd0);
      chk("rst_level",  32'(a_level),   32'd0);
      chk("rst_afull",  32'(a_af),      32'd0);
      chk("rst_aempty", 32'(a_ae),      32'd1);
      chk("rst_b_valid", 32'(b_valid_o), 32'd0);
      adv();

      // Fill with A0..A4, no pops
      for (int i = 0; i < 5; i++) begin
         apply_a(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
         chk("fill_grant",  32'(a_grant_o), 32'd1);
         chk("fill_level",  32'(a_level),   32'(i));
         chk("fill_afull",  32'(a_af),      (i >= 4) ? 32'd1 : 32'd0);
         chk("fill_aempty", 32'(a_ae),      (i <= 1) ? 32'd1 : 32'd0);
         expq.push_back(8'hA0 + 8'(i));
         adv();
      end
      apply_a(1'b0, 8'h00, 1'b0, 1'b0);
      chk("full_level",  32'(a_level),   32'd5);
      chk("full_grant",  32'(a_grant_o), 32'd0);
      chk("full_afull",  32'(a_af),      32'd1);
      chk("full_aempty", 32'(a_ae),      32'd0);
      chk("full_valid",  32'(a_valid_o), 32'd1);
      adv();

      // Full with push+pop: only the pop happens (A0 checked by monitor)
      apply_a(1'b1, 8'hEE, 1'b1, 1'b0);
      chk("fullpp_grant", 32'(a_grant_o), 32'd0);
      adv();
      apply_a(1'b0, 8'h00, 1'b0, 1'b0);
      chk("fullpp_level", 32'(a_level),   32'd4);
      chk("fullpp_grant1", 32'(a_grant_o), 32'd1);
      adv();

      // Sustained push+pop, pointers wrap twice, level stays 4
      for (int i = 0; i < 12; i++) begin
         expq.push_back(8'hB0 + 8'(i));
         apply_a(1'b1, 8'hB0 + 8'(i), 1'b1, 1'b0);
         chk("b2b_level", 32'(a_level), 32'd4);
         adv();
      end
      apply_a(1'b0, 8'h00, 1'b1, 1'b0);
      chk("pop_level_before", 32'(a_level), 32'd4);
      adv();
      apply_a(1'b0, 8'h00, 1'b0, 1'b0);
      chk("pop_level_after", 32'(a_level), 32'd3);
      adv();

      // Clear with a simultaneous push at level 3
      apply_a(1'b1, 8'hCC, 1'b0, 1'b1);
      adv();
      expq.delete();
      apply_a(1'b0, 8'h00, 1'b0, 1'b0);
      chk("clr_level",  32'(a_level), 32'd0);
      chk("clr_valid",  32'(a_valid_o), 32'd0);
      chk("clr_aempty", 32'(a_ae), 32'd1);
      chk("clr_afull",  32'(a_af), 32'd0);
      adv();

      // Post-clear operation, minimum latency of one cycle
      expq.push_back(8'hD0);
      apply_a(1'b1, 8'hD0, 1'b0, 1'b0);
      chk("lat_valid0", 32'(a_valid_o), 32'd0);
      adv();
      apply_a(1'b0, 8'h00, 1'b1, 1'b0);
      chk("lat_valid1", 32'(a_valid_o), 32'd1);
      adv();
      apply_a(1'b0, 8'h00, 1'b0, 1'b0);
      chk("lat_level", 32'(a_level), 32'd0);
      adv();

      // Reset mid-stream at level 4, with clear_i also asserted
      for (int i = 0; i < 4; i++) begin
         expq.push_back(8'hE0 + 8'(i));
         apply_a(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0);
         adv();
      end
      apply_a(1'b0, 8'h00, 1'b0, 1'b0);
      chk("pre_rst_level", 32'(a_level), 32'd4);
      adv();
      rst = 1'b1;
      apply_a(1'b1, 8'hF0, 1'b1, 1'b1);
      adv();
      expq.delete();
      apply_a(1'b0, 8'h00, 1'b0, 1'b0);
      chk("mrst_grant",  32'(a_grant_o), 32'd1);
      chk("mrst_valid",  32'(a_valid_o), 32'd0);
      chk("mrst_level",  32'(a_level),   32'd0);
      chk("mrst_afull",  32'(a_af),      32'd0);
      chk("mrst_aempty", 32'(a_ae),      32'd1);
      adv();
      rst = 1'b0;

      // Fall-through instance
      apply_b(1'b1, 8'h55, 1'b1);
      chk("ft_valid", 32'(b_valid_o), 32'd1);
      chk("ft_data",  32'(b_data_o),  32'h55);
      chk("ft_grant", 32'(b_grant_o), 32'd1);
      adv();
      apply_b(1'b0, 8'h00, 1'b0);
      chk("ft_level", 32'(b_level),   32'd0);
      chk("ft_idle_valid", 32'(b_valid_o), 32'd0);
      adv();
      apply_b(1'b1, 8'h66, 1'b0);
      chk("ft_nogrant_data", 32'(b_data_o), 32'h66);
      adv();
      apply_b(1'b1, 8'h77, 1'b1);
      chk("ft_stored_level", 32'(b_level),   32'd1);
      chk("ft_stored_data",  32'(b_data_o),  32'h66);
      adv();
      apply_b(1'b0, 8'h00, 1'b1);
      chk("ft_pp_level", 32'(b_level),  32'd1);
      chk("ft_pp_data",  32'(b_data_o), 32'h77);
      adv();
      apply_b(1'b0, 8'h00, 1'b0);
      chk("ft_drain_level", 32'(b_level),   32'd0);
      chk("ft_drain_valid", 32'(b_valid_o), 32'd0);
      adv();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
